// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

  typedef enum logic [0:0] {
    FETCH,
    MISS
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: FETCH_WIDTH-wide write port, single read port,
// synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH      = 8,
  parameter int unsigned FETCH_WIDTH = 1,
  localparam int unsigned PW         = $clog2(QDEPTH),
  localparam int unsigned CW         = $clog2(QDEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [31:0]                wr_pc,
  input  logic [32*FETCH_WIDTH-1:0]  wr_instr,
  input  logic                       rd_en,
  output fetch_entry_t               rd_entry,
  output logic [CW-1:0]              count
);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      // Storage is left intact; only the bookkeeping is cleared.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
          mem_q[wr_ptr_q + PW'(i)] <= '{pc: wr_pc + 32'(4 * i), instr: wr_instr[32*i +: 32]};
        end
        wr_ptr_q <= wr_ptr_q + PW'(FETCH_WIDTH);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + (wr_en ? CW'(FETCH_WIDTH) : CW'(0)) - (rd_en ? CW'(1) : CW'(0));
    end
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, FETCH/MISS control and issue logic
// feeding a decoupling instruction queue consumed by ID.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 1,
  parameter int unsigned QDEPTH      = 8,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                             CLK,
  input  logic                             RESET,
  output logic                             IM_Req,
  output logic [31:0]                      IM_Addr,
  input  logic [32*FETCH_WIDTH-1:0]        IM_Instr,
  input  logic                             IM_Valid,
  input  logic                             Hold,
  input  logic                             Redirect,
  input  logic [31:0]                      Redirect_PC,
  output logic                             Out_Valid,
  output logic [31:0]                      Out_Instr,
  output logic [31:0]                      Out_PC,
  output logic [31:0]                      Out_PC_Plus4,
  input  logic                             Deq_Ready,
  output logic [$clog2(QDEPTH+1)-1:0]      Q_Count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         space_ok;
  logic         hit;
  logic         deq;
  fetch_entry_t head;

  // Registered count only; a same-cycle dequeue does not free a slot for issue.
  assign space_ok = (QDEPTH - 32'(Q_Count)) >= FETCH_WIDTH;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    IM_Req     = 1'b0;
    unique case (state_q)
      FETCH: IM_Req = !Hold && !Redirect && space_ok;
      MISS:  IM_Req = !Redirect;
    endcase
    if (RESET) begin
      IM_Req = 1'b0;
    end
    hit = IM_Req && IM_Valid;
    if (hit) begin
      fetch_pc_d = fetch_pc_q + 32'(4 * FETCH_WIDTH);
      state_d    = FETCH;
    end else if (IM_Req) begin
      state_d    = MISS;
    end
    if (Redirect) begin
      fetch_pc_d = Redirect_PC;
      state_d    = FETCH;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign IM_Addr   = fetch_pc_q;
  assign Out_Valid = (Q_Count != '0) && !Redirect;
  assign deq       = Out_Valid && Deq_Ready;

  fetch_queue #(
    .QDEPTH      (QDEPTH),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_queue (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (Redirect),
    .wr_en    (hit),
    .wr_pc    (fetch_pc_q),
    .wr_instr (IM_Instr),
    .rd_en    (deq),
    .rd_entry (head),
    .count    (Q_Count)
  );

  assign Out_Instr    = head.instr;
  assign Out_PC       = head.pc;
  assign Out_PC_Plus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue (FETCH_WIDTH=2, QDEPTH=8) against a
// queue-based behavioural model.
module tb_if_fetch_queue;

  localparam int unsigned FW     = 2;
  localparam int unsigned QD     = 8;
  localparam int unsigned CW     = $clog2(QD + 1);
  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic              CLK;
  logic              RESET;
  logic              IM_Req;
  logic [31:0]       IM_Addr;
  logic [32*FW-1:0]  IM_Instr;
  logic              IM_Valid;
  logic              Hold;
  logic              Redirect;
  logic [31:0]       Redirect_PC;
  logic              Out_Valid;
  logic [31:0]       Out_Instr;
  logic [31:0]       Out_PC;
  logic [31:0]       Out_PC_Plus4;
  logic              Deq_Ready;
  logic [CW-1:0]     Q_Count;

  if_fetch_queue #(
    .FETCH_WIDTH (FW),
    .QDEPTH      (QD),
    .RESET_PC    (RST_PC)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IM_Req       (IM_Req),
    .IM_Addr      (IM_Addr),
    .IM_Instr     (IM_Instr),
    .IM_Valid     (IM_Valid),
    .Hold         (Hold),
    .Redirect     (Redirect),
    .Redirect_PC  (Redirect_PC),
    .Out_Valid    (Out_Valid),
    .Out_Instr    (Out_Instr),
    .Out_PC       (Out_PC),
    .Out_PC_Plus4 (Out_PC_Plus4),
    .Deq_Ready    (Deq_Ready),
    .Q_Count      (Q_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_miss;
  bit          m_rst;
  int          n_vec;
  int          n_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  function automatic bit m_req(input bit h, input bit r);
    if (m_rst) return 1'b0;
    if (m_miss) return !r;
    return !h && !r && (int'(QD) - mq.size() >= int'(FW));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit h, input bit r);
    chk("im_req", 32'(IM_Req), 32'(m_req(h, r)));
    chk("im_addr", IM_Addr, m_pc);
    chk("out_valid", 32'(Out_Valid), 32'((mq.size() != 0) && !r));
    chk("q_count", 32'(Q_Count), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("out_pc", Out_PC, mq[0].pc);
      chk("out_instr", Out_Instr, mq[0].instr);
      chk("out_pc_plus4", Out_PC_Plus4, mq[0].pc + 32'd4);
    end
  endtask

  task automatic model_update(input bit h, input bit r, input logic [31:0] rpc,
                              input bit v, input bit d);
    bit req;
    bit ov;
    req = m_req(h, r);
    ov  = (mq.size() != 0) && !r;
    if (r) begin
      mq.delete();
      m_pc   = rpc;
      m_miss = 1'b0;
    end else begin
      if (ov && d) void'(mq.pop_front());
      if (req && v) begin
        for (int i = 0; i < int'(FW); i++) begin
          mq.push_back('{pc: m_pc + 32'(4 * i), instr: mem_word(m_pc + 32'(4 * i))});
        end
        m_pc   = m_pc + 32'(4 * FW);
        m_miss = 1'b0;
      end else if (req) begin
        m_miss = 1'b1;
      end
    end
  endtask

  task automatic step(input bit h, input bit r, input logic [31:0] rpc, input bit v, input bit d);
    @(negedge CLK);
    Hold        = h;
    Redirect    = r;
    Redirect_PC = rpc;
    IM_Valid    = v;
    Deq_Ready   = d;
    for (int i = 0; i < int'(FW); i++) begin
      IM_Instr[32*i +: 32] = mem_word(m_pc + 32'(4 * i));
    end
    #1;
    check_outputs(h, r);
    @(posedge CLK);
    model_update(h, r, rpc, v, d);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    m_rst  = 1'b1;
    mq.delete();
    m_pc   = RST_PC;
    m_miss = 1'b0;
    chk("rst_im_req", 32'(IM_Req), 32'd0);
    chk("rst_q_count", 32'(Q_Count), 32'd0);
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_out_pc", Out_PC, 32'd0);
    chk("rst_out_instr", Out_Instr, 32'd0);
    chk("rst_out_pc_plus4", Out_PC_Plus4, 32'd4);
    chk("rst_im_addr", IM_Addr, RST_PC);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    m_rst = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    RESET       = 1'b1;
    m_rst       = 1'b1;
    m_pc        = RST_PC;
    m_miss      = 1'b0;
    Hold        = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = '0;
    IM_Valid    = 1'b0;
    Deq_Ready   = 1'b0;
    IM_Instr    = '0;
    do_reset();

    // Fill: four two-wide hits with no dequeue.
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
    #2;
    chk("full_count", 32'(Q_Count), 32'd8);
    chk("full_addr", IM_Addr, 32'hBFC00020);
    chk("full_req", 32'(IM_Req), 32'd0);
    step(0, 0, 0, 1, 1);
    #2;
    chk("one_free_count", 32'(Q_Count), 32'd7);
    chk("one_free_req", 32'(IM_Req), 32'd0);
    step(0, 0, 0, 1, 1);

    // Miss held for several cycles, then redirect with 5 entries while in MISS.
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(0, 1, 32'h80000180, 1, 1);
    #2;
    chk("redir_count", 32'(Q_Count), 32'd0);
    chk("redir_addr", IM_Addr, 32'h80000180);
    step(0, 0, 0, 1, 0);
    #2;
    chk("redir_out_pc", Out_PC, 32'h80000180);
    chk("redir_out_valid", 32'(Out_Valid), 32'd1);

    // Hold drains the queue, then fetch resumes.
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 1);
    #2;
    chk("hold_drained", 32'(Out_Valid), 32'd0);
    step(0, 0, 0, 1, 1);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(7) == 0), ($urandom_range(31) == 0), $urandom() & 32'hFFFFFFFC,
           ($urandom_range(3) != 0), ($urandom_range(2) != 0));
    end

    // Reset in the middle of a miss.
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 1);
    chk("post_reset_pc", m_pc, 32'hBFC00008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
